bsg_cam_1r1w_tag_ctrl: RTL and testbench
========================================

Name: bsg_cam_1r1w_tag_ctrl

Overview:
Command sequencer for bsg_cam_1r1w_tag_array. It serializes insert, remove and flush commands into lookup-then-write sequences on the array's single read port and single write port. Insert always checks for a duplicate first, so the array never holds two entries with the same tag. When the array is full, the victim is chosen by a round-robin pointer. An external lookup port shares the array's read port and is stalled only while the controller is doing its own lookup.

Parameters:
- width_p, "inv", tag width.
- els_p, "inv", number of CAM entries (must be ≥ 2).
- lg_els_lp, `BSG_SAFE_CLOG2(els_p), entry-index width (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- cmd_op_i  in  2  bsg_cam_op_e: e_cam_insert=0, e_cam_remove=1, e_cam_flush=2; 3 is illegal.
- cmd_tag_i  in  width_p  tag for insert or remove.
- done_v_o  out  1  one-cycle completion pulse.
- done_hit_o  out  1  tag was already present (insert) or was found (remove).
- done_evict_o  out  1  insert overwrote a valid entry.
- done_idx_o  out  lg_els_lp  entry index written, matched or evicted.
- lk_v_i  in  1  external lookup valid.
- lk_tag_i  in  width_p  external lookup tag.
- lk_ready_o  out  1  external lookup is serviced this cycle.
- lk_match_o  out  els_p  one-hot or zero match result; valid when lk_v_i & lk_ready_o.
- tag_w_v_o  out  els_p  to array w_v_i.
- tag_w_set_not_clear_o  out  1  to array w_set_not_clear_i.
- tag_w_tag_o  out  width_p  to array w_tag_i.
- tag_w_empty_i  in  els_p  from array w_empty_o.
- tag_r_v_o  out  1  to array r_v_i.
- tag_r_tag_o  out  width_p  to array r_tag_i.
- tag_r_match_i  in  els_p  from array r_match_o.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous and active-high.
- State set: eIDLE, eLOOKUP, eWRITE, eFLUSH.
- Reset: state=eIDLE, rr_ptr=0, flush_cnt=0, done_v_o=0, done_hit_o=0, done_evict_o=0, done_idx_o=0, tag_w_v_o=0.
- Reset mid-operation: the command is aborted, no done pulse is produced, and no partial write occurs after reset rises. The array is reset by the same reset_i.
- cmd_ready_o = (state==eIDLE) & ~reset_i.
- eIDLE, on handshake: latch op_r and tag_r. Insert or remove goes to eLOOKUP. Flush clears flush_cnt and goes to eFLUSH.
- eLOOKUP: tag_r_v_o=1, tag_r_tag_o=tag_r. Register match_r=tag_r_match_i and empty_r=tag_w_empty_i. Go to eWRITE.
- eWRITE, insert:
  - match_r≠0: no write; hit=1; idx=encode(match_r).
  - else empty_r≠0: write set at the lowest-index empty entry; idx=that entry; evict=0.
  - else: write set at rr_ptr; evict=1; idx=rr_ptr; rr_ptr advances, wrapping els_p-1→0.
- eWRITE, remove:
  - match_r≠0: clear with tag_w_v_o=match_r; hit=1; idx=encode(match_r).
  - else: no write; hit=0; idx=0.
- eWRITE exit: go to eIDLE; done fields are registered and valid next cycle.
- eFLUSH: each cycle tag_w_v_o=onehot(flush_cnt) with set_not_clear=0, then flush_cnt++.
  - When flush_cnt==els_p-1, go to eIDLE and reset rr_ptr to 0.
  - Flush done reports hit=0, evict=0, idx=els_p-1.
- Latency: insert/remove handshake in cycle 0, lookup cycle 1, write cycle 2, done_v_o in cycle 3. Flush done_v_o arrives els_p+1 cycles after the handshake.
- A new command may be accepted in the same cycle done_v_o is high.
- Write port: tag_w_tag_o=tag_r at all times. tag_w_set_not_clear_o=1 only on an insert write. tag_w_v_o is 0 in all other states and cases.
- Write one-hot rule: at most one bit of tag_w_v_o is set per cycle.
- Read-port sharing:
  - lk_ready_o = (state≠eLOOKUP) & ~reset_i.
  - tag_r_tag_o = lk_tag_i whenever not in eLOOKUP.
  - tag_r_v_o = lk_v_i whenever not in eLOOKUP.
  - lk_match_o = tag_r_match_i & {els_p{lk_ready_o}}.
- Lookup timing: lookups during eWRITE or eFLUSH see pre-edge array contents.
- Illegal op 3: completes as a no-op insert path with hit=0 and no write. The simulation assertion flags it.
- Simulation assertions: tag_w_v_o is at most one-hot, and match_r is at most one-hot.

Decomposition:
- Package bsg_cam_pkg: bsg_cam_op_e enum and the state enum.
- Sub-modules:
  - bsg_priority_encode (lowest empty entry).
  - bsg_encode_one_hot (match index).
  - bsg_decode (index to one-hot).
  - bsg_counter_clear_up, used for both rr_ptr and flush_cnt.

Test Plan:
- els_p=4: insert 0x11 into an empty array → done in cycle 3 with hit=0, evict=0, idx=0; a lookup of 0x11 then gives lk_match_o=0001.
- Insert 0x11 again → hit=1, idx=0, no write; only one entry matches 0x11.
- Fill entries with 0x11, 0x22, 0x33, 0x44, then insert 0x55 → evict=1, idx=0. Insert 0x66 → evict=1, idx=1. A lookup of 0x11 now gives 0000.
- Remove 0x33 → hit=1, idx=2 and w_empty shows bit 2 set. Remove 0x99 → hit=0, no write. A following insert 0x77 → idx=2.
- Flush → tag_w_v_o walks 0001, 0010, 0100, 1000 in consecutive cycles; done_v_o 5 cycles after the handshake; w_empty=1111; the next full-array insert evicts idx 0.
- Hold lk_v_i=1 during an insert → lk_ready_o=0 only in the eLOOKUP cycle. Asserting reset_i during eWRITE → no done pulse and state returns to eIDLE.

Source files
------------

// File: rtl/bsg_cam_pkg.sv
// Shared types for the tag CAM command sequencer: command opcodes and FSM states.
package bsg_cam_pkg;

   typedef enum logic [1:0] {
      e_cam_insert = 2'd0,
      e_cam_remove = 2'd1,
      e_cam_flush  = 2'd2
   } bsg_cam_op_e;

   typedef enum logic [1:0] {
      eIDLE   = 2'd0,
      eLOOKUP = 2'd1,
      eWRITE  = 2'd2,
      eFLUSH  = 2'd3
   } bsg_cam_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that wraps from max_val_p back to zero.
module bsg_counter_clear_up #(
   parameter int max_val_p = 3,
   localparam int width_lp = (max_val_p > 1) ? $clog2(max_val_p + 1) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                up,
   output logic [width_lp-1:0] count
);

   logic [width_lp-1:0] count_reg;
   logic [width_lp-1:0] count_next;

   always_comb begin
      count_next = clear ? '0 : count_reg;
      if (up) begin
         count_next = (count_next == width_lp'(max_val_p)) ? '0 : count_next + width_lp'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/bsg_decode.sv
// Binary index to one-hot vector.
module bsg_decode #(
   parameter int num_out_p = 4,
   localparam int lg_num_lp = (num_out_p > 1) ? $clog2(num_out_p) : 1
) (
   input  logic [lg_num_lp-1:0] i,
   output logic [num_out_p-1:0] o
);

   for (genvar gi = 0; gi < num_out_p; gi++) begin : g_out
      assign o[gi] = (i == lg_num_lp'(gi));
   end

endmodule

// File: rtl/bsg_encode_one_hot.sv
// Binary index of a one-hot vector; the result is only meaningful when at most one bit is set.
module bsg_encode_one_hot #(
   parameter int width_p = 4,
   localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic [width_p-1:0]     i,
   output logic [lg_width_lp-1:0] addr,
   output logic                   v
);

   // OR of the indices of all set bits: no priority chain needed for one-hot input.
   always_comb begin
      addr = '0;
      for (int k = 0; k < width_p; k++) begin
         if (i[k]) begin
            addr = addr | lg_width_lp'(k);
         end
      end
   end

   assign v = |i;

endmodule

// File: rtl/bsg_priority_encode.sv
// Index of the lowest set bit of a vector, plus an any-bit-set flag.
module bsg_priority_encode #(
   parameter int width_p = 4,
   localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic [width_p-1:0]     i,
   output logic [lg_width_lp-1:0] addr,
   output logic                   v
);

   // Scan high to low so the lowest set bit is the last one to win.
   always_comb begin
      addr = '0;
      for (int k = width_p - 1; k >= 0; k--) begin
         if (i[k]) begin
            addr = lg_width_lp'(k);
         end
      end
   end

   assign v = |i;

endmodule

// File: rtl/bsg_cam_1r1w_tag_ctrl.sv
// Serializes insert/remove/flush into lookup-then-write sequences on a 1r1w tag CAM,
// sharing the array read port with an external lookup requester.
module bsg_cam_1r1w_tag_ctrl
   import bsg_cam_pkg::*;
#(
   parameter int width_p = 8,
   parameter int els_p   = 4,
   localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,

   input  logic                 cmd_v_i,
   output logic                 cmd_ready_o,
   input  logic [1:0]           cmd_op_i,
   input  logic [width_p-1:0]   cmd_tag_i,

   output logic                 done_v_o,
   output logic                 done_hit_o,
   output logic                 done_evict_o,
   output logic [lg_els_lp-1:0] done_idx_o,

   input  logic                 lk_v_i,
   input  logic [width_p-1:0]   lk_tag_i,
   output logic                 lk_ready_o,
   output logic [els_p-1:0]     lk_match_o,

   output logic [els_p-1:0]     tag_w_v_o,
   output logic                 tag_w_set_not_clear_o,
   output logic [width_p-1:0]   tag_w_tag_o,
   input  logic [els_p-1:0]     tag_w_empty_i,

   output logic                 tag_r_v_o,
   output logic [width_p-1:0]   tag_r_tag_o,
   input  logic [els_p-1:0]     tag_r_match_i
);

   bsg_cam_state_e state_reg, state_next;

   logic [1:0]           op_reg;
   logic [width_p-1:0]   tag_reg;
   logic [els_p-1:0]     match_reg;
   logic [els_p-1:0]     empty_reg;

   logic                 done_v_reg,     done_v_next;
   logic                 done_hit_reg,   done_hit_next;
   logic                 done_evict_reg, done_evict_next;
   logic [lg_els_lp-1:0] done_idx_reg,   done_idx_next;

   logic                 latch_cmd;
   logic [els_p-1:0]     w_v;
   logic                 w_set;
   logic                 rr_up, rr_clear;
   logic                 flush_up, flush_clear;

   logic [lg_els_lp-1:0] rr_ptr;
   logic [lg_els_lp-1:0] flush_cnt;
   logic [lg_els_lp-1:0] lowest_empty_idx;
   logic                 empty_any;
   logic [lg_els_lp-1:0] match_idx;
   logic                 match_any;
   logic [lg_els_lp-1:0] dec_idx;
   logic [els_p-1:0]     dec_onehot;

   bsg_priority_encode #(.width_p(els_p)) lowest_empty (
      .i    (empty_reg),
      .addr (lowest_empty_idx),
      .v    (empty_any)
   );

   bsg_encode_one_hot #(.width_p(els_p)) match_enc (
      .i    (match_reg),
      .addr (match_idx),
      .v    (match_any)
   );

   // One decoder serves both the flush walk and the insert target slot.
   assign dec_idx = (state_reg == eFLUSH) ? flush_cnt
                  : (empty_any ? lowest_empty_idx : rr_ptr);

   bsg_decode #(.num_out_p(els_p)) write_dec (
      .i (dec_idx),
      .o (dec_onehot)
   );

   bsg_counter_clear_up #(.max_val_p(els_p - 1)) rr_counter (
      .clk   (clk_i),
      .reset (reset_i),
      .clear (rr_clear),
      .up    (rr_up),
      .count (rr_ptr)
   );

   bsg_counter_clear_up #(.max_val_p(els_p - 1)) flush_counter (
      .clk   (clk_i),
      .reset (reset_i),
      .clear (flush_clear),
      .up    (flush_up),
      .count (flush_cnt)
   );

   assign cmd_ready_o = (state_reg == eIDLE) & ~reset_i;

   always_comb begin
      state_next      = state_reg;
      latch_cmd       = 1'b0;
      w_v             = '0;
      w_set           = 1'b0;
      rr_up           = 1'b0;
      rr_clear        = 1'b0;
      flush_up        = 1'b0;
      flush_clear     = 1'b0;
      done_v_next     = 1'b0;
      done_hit_next   = 1'b0;
      done_evict_next = 1'b0;
      done_idx_next   = '0;

      case (state_reg)
         eIDLE: begin
            if (cmd_v_i & cmd_ready_o) begin
               latch_cmd = 1'b1;
               if (cmd_op_i == e_cam_flush) begin
                  flush_clear = 1'b1;
                  state_next  = eFLUSH;
               end else begin
                  state_next  = eLOOKUP;
               end
            end
         end

         eLOOKUP: begin
            state_next = eWRITE;
         end

         eWRITE: begin
            state_next  = eIDLE;
            done_v_next = 1'b1;
            if (op_reg == e_cam_remove) begin
               if (match_any) begin
                  w_v           = match_reg;
                  done_hit_next = 1'b1;
                  done_idx_next = match_idx;
               end
            end else if (op_reg == e_cam_insert) begin
               if (match_any) begin
                  done_hit_next = 1'b1;
                  done_idx_next = match_idx;
               end else begin
                  w_v           = dec_onehot;
                  w_set         = 1'b1;
                  done_idx_next = dec_idx;
                  if (!empty_any) begin
                     done_evict_next = 1'b1;
                     rr_up           = 1'b1;
                  end
               end
            end
            // Illegal opcode falls through here: a completion with no write.
         end

         eFLUSH: begin
            w_v      = dec_onehot;
            flush_up = 1'b1;
            if (flush_cnt == lg_els_lp'(els_p - 1)) begin
               state_next    = eIDLE;
               rr_clear      = 1'b1;
               done_v_next   = 1'b1;
               done_idx_next = lg_els_lp'(els_p - 1);
            end
         end

         default: begin
            state_next = eIDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg      <= eIDLE;
         op_reg         <= '0;
         tag_reg        <= '0;
         match_reg      <= '0;
         empty_reg      <= '0;
         done_v_reg     <= 1'b0;
         done_hit_reg   <= 1'b0;
         done_evict_reg <= 1'b0;
         done_idx_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         done_v_reg <= done_v_next;
         if (latch_cmd) begin
            op_reg  <= cmd_op_i;
            tag_reg <= cmd_tag_i;
         end
         if (state_reg == eLOOKUP) begin
            match_reg <= tag_r_match_i;
            empty_reg <= tag_w_empty_i;
         end
         if (done_v_next) begin
            done_hit_reg   <= done_hit_next;
            done_evict_reg <= done_evict_next;
            done_idx_reg   <= done_idx_next;
         end
      end
   end

   assign done_v_o     = done_v_reg;
   assign done_hit_o   = done_hit_reg;
   assign done_evict_o = done_evict_reg;
   assign done_idx_o   = done_idx_reg;

   // Gate writes with reset so an aborted command leaves nothing half-written.
   assign tag_w_v_o             = w_v & {els_p{~reset_i}};
   assign tag_w_set_not_clear_o = w_set & ~reset_i;
   assign tag_w_tag_o           = tag_reg;

   assign tag_r_v_o   = (state_reg == eLOOKUP) ? 1'b1    : lk_v_i;
   assign tag_r_tag_o = (state_reg == eLOOKUP) ? tag_reg : lk_tag_i;
   assign lk_ready_o  = (state_reg != eLOOKUP) & ~reset_i;
   assign lk_match_o  = tag_r_match_i & {els_p{lk_ready_o}};

   a_write_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(tag_w_v_o));
   a_match_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(match_reg));
   a_legal_op:     assert property (@(posedge clk_i) disable iff (reset_i)
                                    (cmd_v_i & cmd_ready_o) |-> (cmd_op_i != 2'd3));

endmodule

// File: tb/tb_bsg_cam_1r1w_tag_ctrl.sv
// Bench for the tag CAM sequencer: behavioural array stand-in, set-level model and per-cycle compare.
module tb_bsg_cam_1r1w_tag_ctrl;

   localparam int W = 8;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          cmd_v_i = 1'b0;
   logic          cmd_ready_o;
   logic [1:0]    cmd_op_i = '0;
   logic [W-1:0]  cmd_tag_i = '0;
   logic          done_v_o, done_hit_o, done_evict_o;
   logic [1:0]    done_idx_o;
   logic          lk_v_i = 1'b0;
   logic [W-1:0]  lk_tag_i = '0;
   logic          lk_ready_o;
   logic [N-1:0]  lk_match_o;
   logic [N-1:0]  tag_w_v_o;
   logic          tag_w_set_not_clear_o;
   logic [W-1:0]  tag_w_tag_o;
   logic [N-1:0]  tag_w_empty_i;
   logic          tag_r_v_o;
   logic [W-1:0]  tag_r_tag_o;
   logic [N-1:0]  tag_r_match_i;

   always #5 clk = ~clk;

   bsg_cam_1r1w_tag_ctrl #(.width_p(W), .els_p(N)) dut (
      .clk_i                 (clk),
      .reset_i               (reset_i),
      .cmd_v_i               (cmd_v_i),
      .cmd_ready_o           (cmd_ready_o),
      .cmd_op_i              (cmd_op_i),
      .cmd_tag_i             (cmd_tag_i),
      .done_v_o              (done_v_o),
      .done_hit_o            (done_hit_o),
      .done_evict_o          (done_evict_o),
      .done_idx_o            (done_idx_o),
      .lk_v_i                (lk_v_i),
      .lk_tag_i              (lk_tag_i),
      .lk_ready_o            (lk_ready_o),
      .lk_match_o            (lk_match_o),
      .tag_w_v_o             (tag_w_v_o),
      .tag_w_set_not_clear_o (tag_w_set_not_clear_o),
      .tag_w_tag_o           (tag_w_tag_o),
      .tag_w_empty_i         (tag_w_empty_i),
      .tag_r_v_o             (tag_r_v_o),
      .tag_r_tag_o           (tag_r_tag_o),
      .tag_r_match_i         (tag_r_match_i)
   );

   // Stand-in for the tag array: combinational match, write at the clock edge.
   logic [N-1:0] arr_v;
   logic [W-1:0] arr_tag [N];

   always @(posedge clk) begin
      if (reset_i) begin
         arr_v <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (tag_w_v_o[i]) begin
               arr_v[i] <= tag_w_set_not_clear_o;
               if (tag_w_set_not_clear_o) arr_tag[i] <= tag_w_tag_o;
            end
         end
      end
   end

   assign tag_w_empty_i = ~arr_v;

   always_comb begin
      tag_r_match_i = '0;
      for (int i = 0; i < N; i++) begin
         tag_r_match_i[i] = tag_r_v_o && arr_v[i] && (arr_tag[i] == tag_r_tag_o);
      end
   end

   // Set-level model of what the CAM should hold.
   logic         m_v   [N];
   logic [W-1:0] m_tag [N];
   int           m_rr;

   typedef struct {
      int   due;
      logic hit;
      logic evict;
      int   idx;
   } exp_t;

   exp_t         dq[$];
   logic [N-1:0] exp_wv   [int];
   logic         exp_set  [int];
   logic [W-1:0] exp_wtag [int];
   logic [W-1:0] exp_rtag [int];

   int chk = 0;
   int fails = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
      chk++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s cyc=%0d: got %0h required %0h", name, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [N-1:0] ewv;
      bit           busy;
      exp_t         e;
      if (mon_en) begin
         busy = exp_rtag.exists(cyc);
         ewv  = exp_wv.exists(cyc) ? exp_wv[cyc] : '0;
         chk_eq("tag_w_v", 64'(tag_w_v_o), 64'(ewv));
         if (ewv != '0) begin
            chk_eq("w_set", 64'(tag_w_set_not_clear_o), 64'(exp_set[cyc]));
            chk_eq("w_tag", 64'(tag_w_tag_o), 64'(exp_wtag[cyc]));
         end
         chk_eq("lk_ready", 64'(lk_ready_o), 64'(!busy && !reset_i));
         chk_eq("r_v", 64'(tag_r_v_o), 64'(busy ? 1'b1 : lk_v_i));
         if (busy) begin
            chk_eq("r_tag_busy", 64'(tag_r_tag_o), 64'(exp_rtag[cyc]));
            chk_eq("lk_match_busy", 64'(lk_match_o), 64'(0));
         end else begin
            chk_eq("r_tag", 64'(tag_r_tag_o), 64'(lk_tag_i));
         end
         if (dq.size() > 0 && dq[0].due < cyc) begin
            chk++;
            fails++;
            $display("FAIL done_missing cyc=%0d: got no pulse required pulse at %0d", cyc, dq[0].due);
            void'(dq.pop_front());
         end
         if (done_v_o) begin
            if (dq.size() == 0) begin
               chk++;
               fails++;
               $display("FAIL done_spurious cyc=%0d: got pulse required none", cyc);
            end else begin
               e = dq.pop_front();
               chk_eq("done_cycle", 64'(cyc), 64'(e.due));
               chk_eq("done_hit", 64'(done_hit_o), 64'(e.hit));
               chk_eq("done_evict", 64'(done_evict_o), 64'(e.evict));
               chk_eq("done_idx", 64'(done_idx_o), 64'(e.idx));
            end
         end
      end
   end

   task automatic model_apply(input logic [1:0] op, input logic [W-1:0] tag, input int c,
                              output logic hit, output logic ev, output int idx);
      int slot;
      hit = 1'b0;
      ev  = 1'b0;
      idx = 0;
      slot = -1;
      if (op == 2'd0) begin
         for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == tag) begin hit = 1'b1; idx = i; end
         if (!hit) begin
            for (int i = N - 1; i >= 0; i--) if (!m_v[i]) slot = i;
            if (slot < 0) begin
               slot = m_rr;
               ev   = 1'b1;
               m_rr = (m_rr + 1) % N;
            end
            idx = slot;
            m_v[slot] = 1'b1;
            m_tag[slot] = tag;
            exp_wv[c+2] = N'(1) << slot;
            exp_set[c+2] = 1'b1;
            exp_wtag[c+2] = tag;
         end
      end else if (op == 2'd1) begin
         for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == tag) begin hit = 1'b1; idx = i; end
         if (hit) begin
            m_v[idx] = 1'b0;
            exp_wv[c+2] = N'(1) << idx;
            exp_set[c+2] = 1'b0;
            exp_wtag[c+2] = tag;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            m_v[k] = 1'b0;
            exp_wv[c+1+k] = N'(1) << k;
            exp_set[c+1+k] = 1'b0;
            exp_wtag[c+1+k] = tag;
         end
         m_rr = 0;
         idx  = N - 1;
      end
   endtask

   // Called just after a rising edge; returns just after the edge following the handshake.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] tag, input bit abort,
                        input logic hh, input logic he, input int hi);
      int   waited;
      int   c;
      logic hit, ev;
      int   idx;
      waited = 0;
      while (!cmd_ready_o && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!cmd_ready_o) begin
         chk++;
         fails++;
         $display("FAIL cmd_ready_timeout cyc=%0d: got ready=0 required ready=1", cyc);
         return;
      end
      c = cyc;
      cmd_v_i = 1'b1;
      cmd_op_i = op;
      cmd_tag_i = tag;
      if (op != 2'd2) exp_rtag[c+1] = tag;
      if (!abort) begin
         model_apply(op, tag, c, hit, ev, idx);
         chk_eq("model_hit", 64'(hit), 64'(hh));
         chk_eq("model_evict", 64'(ev), 64'(he));
         chk_eq("model_idx", 64'(idx), 64'(hi));
         dq.push_back('{due: c + ((op == 2'd2) ? N + 1 : 3), hit: hit, evict: ev, idx: idx});
      end
      @(posedge clk); #1;
      cmd_v_i = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (dq.size() > 0 && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      if (dq.size() > 0) begin
         chk++;
         fails++;
         $display("FAIL drain_timeout cyc=%0d: got %0d pending required 0", cyc, dq.size());
         dq.delete();
      end
   endtask

   task automatic lookup(input logic [W-1:0] tag, input logic [N-1:0] hand);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == tag) m[i] = 1'b1;
      chk_eq("model_lookup", 64'(m), 64'(hand));
      lk_v_i = 1'b1;
      lk_tag_i = tag;
      #1;
      chk_eq("lk_match", 64'(lk_match_o), 64'(m));
      @(posedge clk); #1;
      lk_v_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish required finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin m_v[i] = 1'b0; m_tag[i] = '0; end
      m_rr = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_done_v", 64'(done_v_o), 64'(0));
      chk_eq("rst_done_hit", 64'(done_hit_o), 64'(0));
      chk_eq("rst_done_evict", 64'(done_evict_o), 64'(0));
      chk_eq("rst_done_idx", 64'(done_idx_o), 64'(0));
      chk_eq("rst_w_v", 64'(tag_w_v_o), 64'(0));
      chk_eq("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
      chk_eq("rst_lk_ready", 64'(lk_ready_o), 64'(0));
      reset_i = 1'b0;
      #1;
      chk_eq("idle_cmd_ready", 64'(cmd_ready_o), 64'(1));
      chk_eq("idle_lk_ready", 64'(lk_ready_o), 64'(1));
      mon_en = 1'b1;

      issue(2'd0, 8'h11, 0, 0, 0, 0);
      drain();
      lookup(8'h11, 4'b0001);
      issue(2'd0, 8'h11, 0, 1, 0, 0);
      drain();
      lookup(8'h11, 4'b0001);

      issue(2'd0, 8'h22, 0, 0, 0, 1);
      issue(2'd0, 8'h33, 0, 0, 0, 2);
      issue(2'd0, 8'h44, 0, 0, 0, 3);
      issue(2'd0, 8'h55, 0, 0, 1, 0);
      issue(2'd0, 8'h66, 0, 0, 1, 1);
      drain();
      lookup(8'h11, 4'b0000);
      lookup(8'h55, 4'b0001);
      lookup(8'h66, 4'b0010);

      issue(2'd1, 8'h33, 0, 1, 0, 2);
      drain();
      chk_eq("empty_after_remove", 64'(tag_w_empty_i), 64'(4'b0100));
      issue(2'd1, 8'h99, 0, 0, 0, 0);
      issue(2'd0, 8'h77, 0, 0, 0, 2);
      drain();
      lookup(8'h77, 4'b0100);
      lookup(8'h33, 4'b0000);

      issue(2'd2, 8'h00, 0, 0, 0, 3);
      drain();
      chk_eq("empty_after_flush", 64'(tag_w_empty_i), 64'(4'b1111));
      lookup(8'h44, 4'b0000);
      issue(2'd0, 8'ha1, 0, 0, 0, 0);
      issue(2'd0, 8'ha2, 0, 0, 0, 1);
      issue(2'd0, 8'ha3, 0, 0, 0, 2);
      issue(2'd0, 8'ha4, 0, 0, 0, 3);
      issue(2'd0, 8'ha5, 0, 0, 1, 0);
      drain();
      lookup(8'ha1, 4'b0000);
      lookup(8'ha5, 4'b0001);

      lk_v_i = 1'b1;
      lk_tag_i = 8'ha2;
      issue(2'd0, 8'hb0, 0, 0, 1, 1);
      drain();
      lk_v_i = 1'b0;
      lookup(8'ha2, 4'b0000);

      issue(2'd0, 8'hc0, 1, 0, 0, 0);
      @(posedge clk); #1;
      reset_i = 1'b1;
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_rr = 0;
      @(posedge clk); #1;
      reset_i = 1'b0;
      #1;
      chk_eq("abort_cmd_ready", 64'(cmd_ready_o), 64'(1));
      chk_eq("abort_done_v", 64'(done_v_o), 64'(0));
      repeat (4) @(posedge clk);
      #1;
      issue(2'd0, 8'h11, 0, 0, 0, 0);
      drain();
      lookup(8'h11, 4'b0001);
      lookup(8'hc0, 4'b0000);

      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
      $finish;
   end

endmodule
